yadmc_cmd_arbiter: RTL
======================

YADMC_CMD_ARBITER -- requirements
Module: yadmc_cmd_arbiter

Interface
REQ-001 SHALL have parameter sdram_depth, default 25, SDRAM byte-address width.
REQ-002 SHALL have parameter cache_linedepth, default 2, log2 of cache words per line.
REQ-003 SHALL have parameter timeout_cycles, default 1023, maximum cycles waiting for command_ack.
REQ-004 SHALL derive AW = sdram_depth-cache_linedepth-2 (21 at defaults) as the line-address width.
REQ-005 SHALL have ports:
  sdram_clk  in  1  sole clock, rising edge.
  sdram_rst_n  in  1  reset, asynchronous, active-low.
  req_evict  in  2  per-requester evict request.
  req_refill  in  2  per-requester refill request.
  req_evict_adr  in  2*AW  per-requester evict line address; requester r uses bits [r*AW +: AW].
  req_refill_adr  in  2*AW  per-requester refill line address, same packing.
  req_done  out  2  one-cycle completion pulse per requester.
  command_evict  out  1  evict command to the SDRAM controller.
  command_refill  out  1  refill command to the SDRAM controller.
  evict_adr  out  AW  registered evict address.
  refill_adr  out  AW  registered refill address.
  command_ack  in  1  controller completion, one-cycle pulse.
  err_clr  in  1  clears timeout_err.
  timeout_err  out  1  sticky timeout flag.
  busy  out  1  high in any state other than IDLE.

Function
REQ-006 SHALL implement the FSM states IDLE, CMD and DONE.
REQ-007 SHALL treat requester r as requesting when req_evict[r] | req_refill[r] is high.
REQ-008 In IDLE with at least one requester requesting, SHALL grant one requester by round-robin, latch that requester's bits and addresses, and enter CMD.
REQ-009 SHALL let the round-robin pointer favour the requester not granted last; after reset, requester 0 is favoured.
REQ-010 In CMD, SHALL drive command_evict, command_refill, evict_adr and refill_adr from registers, holding them stable until exit.
REQ-011 SHALL assert both command_evict and command_refill in the same command when the granted requester raised both (write-back, then refill).
REQ-012 SHALL have latency as follows: a request sampled at edge N in IDLE asserts the commands from edge N onward.
REQ-013 When command_ack is sampled high at edge M in CMD, SHALL:
  - deassert the commands at edge M;
  - enter DONE;
  - pulse req_done[grant] for exactly the cycle following M.
REQ-014 DONE SHALL last one cycle and then return to IDLE, so the earliest next grant is at edge M+2.
REQ-015 SHALL let a requester drop or renew its request in the cycle of its req_done pulse, without a spurious re-grant.
REQ-016 SHALL ignore command_ack while in IDLE or DONE.
REQ-017 SHALL ignore requests that withdraw while granted; the command completes normally.
REQ-018 SHALL run a CMD wait counter of width clog2(timeout_cycles+1), cleared on entry to CMD.
REQ-019 If the wait counter reaches timeout_cycles without an ack, SHALL:
  - drop the commands;
  - set timeout_err;
  - pulse req_done[grant];
  - enter DONE.
REQ-020 If ack and timeout coincide in the same cycle, the ack SHALL win and timeout_err SHALL remain unchanged.
REQ-021 SHALL keep timeout_err set until err_clr is sampled high; if set and clear coincide, the set SHALL win.
REQ-022 SHALL never assert command_evict or command_refill outside CMD.
REQ-023 SHALL keep req_done one-hot or zero at all times.

Reset
REQ-024 While sdram_rst_n is low, SHALL immediately force the following, regardless of the clock:
  - state to IDLE;
  - req_done, command_evict, command_refill, evict_adr, refill_adr, timeout_err and busy to 0;
  - wait counter and round-robin pointer to 0.
REQ-025 After reset is released mid-command, SHALL issue no residual command; an outstanding controller ack SHALL be ignored under REQ-016.

Structure
REQ-026 SHALL place the state enum, the AW derivation function and the default timeout constant in the shared package yadmc_pkg.
REQ-027 SHALL implement the two-way round-robin grant logic as the sub-module yadmc_rr_arb2, with inputs req[1:0] and advance, and output a one-hot grant[1:0].

Verification
REQ-028 SHALL verify a single refill: req_refill=2'b01 with address 21'h0ABCD -> refill_adr=21'h0ABCD and command_refill high from the next edge; ack after 10 cycles -> req_done=2'b01 for one cycle.
REQ-029 SHALL verify contention: both requesters request continuously with 3-cycle acks -> grants alternate 0,1,0,1, with no starvation.
REQ-030 SHALL verify combined evict plus refill from requester 1 -> command_evict and command_refill high in the same cycles, and a single req_done[1] pulse.
REQ-031 SHALL verify timeout: with timeout_cycles=15 and no ack -> commands drop after 15 CMD cycles, timeout_err=1, req_done pulses; err_clr -> timeout_err=0.
REQ-032 SHALL verify reset mid-operation: sdram_rst_n low in CMD -> all outputs 0 asynchronously; an ack after release -> no req_done.

Source files
------------

// File: rtl/yadmc_pkg.sv
// Shared definitions for the yadmc command arbiter: FSM encoding, the
// line-address width rule and the default ack timeout.
package yadmc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

    // Line address drops the in-line word offset and the byte-in-word bits.
    function automatic int calc_line_aw(input int sdram_depth, input int cache_linedepth);
        return sdram_depth - cache_linedepth - 2;
    endfunction

endpackage

// File: rtl/yadmc_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves past the
// winner whenever advance is high and something was granted.
module yadmc_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // ptr_q == 1 means requester 1 wins a tie.
    logic ptr_q, ptr_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && (grant != 2'b00))
            ptr_d = grant[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= 1'b0;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/yadmc_cmd_arbiter.sv
// Arbitrates evict/refill requests from two cache requesters onto a single
// SDRAM controller command port, with an ack timeout and sticky error flag.
module yadmc_cmd_arbiter
    import yadmc_pkg::*;
#(
    parameter int  sdram_depth     = 25,
    parameter int  cache_linedepth = 2,
    parameter int  timeout_cycles  = DEFAULT_TIMEOUT_CYCLES,
    localparam int AW              = calc_line_aw(sdram_depth, cache_linedepth)
) (
    input  logic            sdram_clk,
    input  logic            sdram_rst_n,
    input  logic [1:0]      req_evict,
    input  logic [1:0]      req_refill,
    input  logic [2*AW-1:0] req_evict_adr,
    input  logic [2*AW-1:0] req_refill_adr,
    output logic [1:0]      req_done,
    output logic            command_evict,
    output logic            command_refill,
    output logic [AW-1:0]   evict_adr,
    output logic [AW-1:0]   refill_adr,
    input  logic            command_ack,
    input  logic            err_clr,
    output logic            timeout_err,
    output logic            busy
);

    localparam int             CW      = $clog2(timeout_cycles + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(timeout_cycles - 1);

    state_e          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            cmd_evict_q, cmd_evict_d;
    logic            cmd_refill_q, cmd_refill_d;
    logic [AW-1:0]   evict_adr_q, evict_adr_d;
    logic [AW-1:0]   refill_adr_q, refill_adr_d;
    logic [1:0]      req_done_q, req_done_d;
    logic            timeout_err_q, timeout_err_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

    logic [1:0]      req_any;
    logic [1:0]      arb_grant;
    logic            arb_advance;
    logic            set_err;
    logic [AW-1:0]   evict_lane  [2];
    logic [AW-1:0]   refill_lane [2];

    assign req_any     = req_evict | req_refill;
    assign arb_advance = (state_q == ST_IDLE);

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign evict_lane[gi]  = req_evict_adr[gi*AW +: AW];
        assign refill_lane[gi] = req_refill_adr[gi*AW +: AW];
    end

    yadmc_rr_arb2 u_rr (
        .clk     (sdram_clk),
        .rst_n   (sdram_rst_n),
        .req     (req_any),
        .advance (arb_advance),
        .grant   (arb_grant)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cmd_evict_d  = cmd_evict_q;
        cmd_refill_d = cmd_refill_q;
        evict_adr_d  = evict_adr_q;
        refill_adr_d = refill_adr_q;
        wait_cnt_d   = wait_cnt_q;
        req_done_d   = 2'b00;
        set_err      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_any != 2'b00) begin
                    state_d      = ST_CMD;
                    grant_d      = arb_grant;
                    cmd_evict_d  = |(req_evict & arb_grant);
                    cmd_refill_d = |(req_refill & arb_grant);
                    evict_adr_d  = evict_lane[arb_grant[1]];
                    refill_adr_d = refill_lane[arb_grant[1]];
                    wait_cnt_d   = '0;
                end
            end
            ST_CMD: begin
                // An ack on the final allowed cycle still counts as success.
                if (command_ack || (wait_cnt_q == TO_LAST)) begin
                    state_d      = ST_DONE;
                    cmd_evict_d  = 1'b0;
                    cmd_refill_d = 1'b0;
                    req_done_d   = grant_q;
                    set_err      = !command_ack;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        timeout_err_d = set_err ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= 2'b00;
            cmd_evict_q   <= 1'b0;
            cmd_refill_q  <= 1'b0;
            evict_adr_q   <= '0;
            refill_adr_q  <= '0;
            req_done_q    <= 2'b00;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            cmd_evict_q   <= cmd_evict_d;
            cmd_refill_q  <= cmd_refill_d;
            evict_adr_q   <= evict_adr_d;
            refill_adr_q  <= refill_adr_d;
            req_done_q    <= req_done_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign req_done       = req_done_q;
    assign command_evict  = cmd_evict_q;
    assign command_refill = cmd_refill_q;
    assign evict_adr      = evict_adr_q;
    assign refill_adr     = refill_adr_q;
    assign timeout_err    = timeout_err_q;
    assign busy           = (state_q != ST_IDLE);

endmodule
